// File: rtl/audio_output_stage_if.sv
// Sample input stream into the audio output stage: sample, routing and the
// valid/ready handshake.
interface audio_output_stage_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 16
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                    mono;
  logic signed [WIDTH-1:0] in_sample;
  logic [CW-1:0]           in_channel;
  logic                    in_write;
  logic                    in_ready;

  modport master (output mono, in_sample, in_channel, in_write, input in_ready);
  modport slave  (input mono, in_sample, in_channel, in_write, output in_ready);
endinterface

// File: rtl/audio_output_stage.sv
// Multi-channel audio playout: per-channel FWFT sample FIFOs, pre-buffered
// start, rate-paced lockstep pops, underrun stop and DC decay while idle.
module audio_output_stage #(
  parameter int CHANNELS    = 2,
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 1024,
  parameter int START_LEVEL = 768,
  parameter int START_DELAY = 2,
  parameter int DECAY_DIV   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sample_tick37,
  input  logic                      sample_tick44,
  input  logic [1:0]                rate,
  input  logic                      flush,
  audio_output_stage_if.slave       src,
  output logic [CHANNELS*WIDTH-1:0] out_sample,
  output logic                      out_strobe,
  output logic                      playing,
  output logic                      underrun,
  output logic [$clog2(DEPTH):0]    level0
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMING = 2'd1, S_PLAY = 2'd2} state_t;

  logic signed [WIDTH-1:0] mem_r  [CHANNELS][DEPTH];
  logic [AW-1:0]           wr_ptr_r [CHANNELS];
  logic [AW-1:0]           rd_ptr_r [CHANNELS];
  logic [LW-1:0]           level_r  [CHANNELS];
  logic signed [WIDTH-1:0] head_s   [CHANNELS];
  logic signed [WIDTH-1:0] out_r    [CHANNELS];
  logic [CHANNELS-1:0]     full_s, empty_s, start_ok_s, wr_en_s;
  state_t                  state_r, state_s;
  logic [3:0]              delay_r, delay_s;
  logic [DW-1:0]           decay_cnt_r;
  logic                    decay_wrap_s, toggle18_r, base_tick_s, pace_s;
  logic                    pop_s, underrun_s, ready_s;
  logic                    strobe_r, playing_r, underrun_r;

  function automatic logic signed [WIDTH-1:0] decay_step(input logic signed [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      decay_step = v + WIDTH'(1);
    end else if (v != '0) begin
      decay_step = v - WIDTH'(1);
    end else begin
      decay_step = v;
    end
  endfunction

  // FIFO status flags and heads
  always_comb begin
    full_s     = '0;
    empty_s    = '0;
    start_ok_s = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      full_s[c]     = (level_r[c] == LW'(DEPTH));
      empty_s[c]    = (level_r[c] == LW'(0));
      start_ok_s[c] = (level_r[c] >= LW'(START_LEVEL));
      head_s[c]     = mem_r[c][rd_ptr_r[c]];
    end
  end

  // Input routing; an out-of-range channel is accepted and dropped
  always_comb begin
    ready_s = 1'b1;
    wr_en_s = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (src.mono) begin
        ready_s    = ready_s & ~full_s[c];
        wr_en_s[c] = 1'b1;
      end else if (src.in_channel == CW'(c)) begin
        ready_s    = ready_s & ~full_s[c];
        wr_en_s[c] = 1'b1;
      end else begin
        wr_en_s[c] = 1'b0;
      end
    end
    wr_en_s = wr_en_s & {CHANNELS{src.in_write & ready_s & ~flush}};
  end

  assign src.in_ready = ready_s;

  // Rate selection: 18.9 kHz takes every other 37.8 kHz tick
  always_comb begin
    base_tick_s = (rate == 2'd0) ? sample_tick44 : sample_tick37;
    case (rate)
      2'd0:    pace_s = sample_tick44;
      2'd2:    pace_s = sample_tick37 & toggle18_r;
      default: pace_s = sample_tick37;
    endcase
  end

  // Playout state machine: next state, pop and underrun decisions
  always_comb begin
    state_s    = state_r;
    delay_s    = delay_r;
    pop_s      = 1'b0;
    underrun_s = 1'b0;
    if (flush) begin
      state_s = S_IDLE;
      delay_s = 4'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (&start_ok_s) begin
            state_s = S_ARMING;
          end else begin
            state_s = S_IDLE;
          end
          delay_s = 4'd0;
        end
        S_ARMING: begin
          if (!(&start_ok_s)) begin
            state_s = S_IDLE;
            delay_s = 4'd0;
          end else if (base_tick_s) begin
            if (delay_r + 4'd1 == 4'(START_DELAY)) begin
              state_s = S_PLAY;
              delay_s = 4'd0;
            end else begin
              delay_s = delay_r + 4'd1;
            end
          end else begin
            delay_s = delay_r;
          end
        end
        S_PLAY: begin
          if (!pace_s) begin
            state_s = S_PLAY;
          end else if (|empty_s) begin
            // never pop a partial frame: channels must stay aligned
            underrun_s = 1'b1;
            state_s    = S_IDLE;
          end else begin
            pop_s = 1'b1;
          end
        end
        default: begin
          state_s = S_IDLE;
          delay_s = 4'd0;
        end
      endcase
    end
  end

  // Control registers, rate toggle and decay prescaler
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      delay_r     <= 4'd0;
      playing_r   <= 1'b0;
      underrun_r  <= 1'b0;
      strobe_r    <= 1'b0;
      toggle18_r  <= 1'b0;
      decay_cnt_r <= '0;
    end else begin
      state_r     <= state_s;
      delay_r     <= delay_s;
      playing_r   <= (state_s == S_PLAY);
      underrun_r  <= underrun_s;
      strobe_r    <= pop_s;
      toggle18_r  <= toggle18_r ^ sample_tick37;
      decay_cnt_r <= (flush || decay_wrap_s) ? '0 : decay_cnt_r + DW'(1);
    end
  end

  assign decay_wrap_s = (decay_cnt_r == DW'(DECAY_DIV - 1));

  // FIFO pointers and levels; flush wins over any same-cycle pop or write
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (reset || flush) begin
        wr_ptr_r[c] <= '0;
        rd_ptr_r[c] <= '0;
        level_r[c]  <= '0;
      end else begin
        if (wr_en_s[c]) wr_ptr_r[c] <= wr_ptr_r[c] + AW'(1);
        if (pop_s)      rd_ptr_r[c] <= rd_ptr_r[c] + AW'(1);
        case ({wr_en_s[c], pop_s})
          2'b10:   level_r[c] <= level_r[c] + LW'(1);
          2'b01:   level_r[c] <= level_r[c] - LW'(1);
          default: level_r[c] <= level_r[c];
        endcase
      end
    end
  end

  // Sample storage
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (wr_en_s[c]) mem_r[c][wr_ptr_r[c]] <= src.in_sample;
    end
  end

  // Output samples: load on pop, otherwise decay toward zero outside PLAY
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (reset) begin
        out_r[c] <= '0;
      end else if (pop_s) begin
        out_r[c] <= head_s[c];
      end else if (state_r != S_PLAY && decay_wrap_s) begin
        out_r[c] <= decay_step(out_r[c]);
      end else begin
        out_r[c] <= out_r[c];
      end
    end
  end

  // Output packing
  always_comb begin
    out_sample = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      out_sample[c*WIDTH +: WIDTH] = out_r[c];
    end
  end

  assign out_strobe = strobe_r;
  assign playing    = playing_r;
  assign underrun   = underrun_r;
  assign level0     = level_r[0];
endmodule
